// File: rtl/bam_rr_scheduler.sv
// Round-robin front end sharing one BAM_top approximate multiplier among NREQ
// requesters: issue register (S1) -> combinational BAM_top -> result register (S2).

// One partial-product row of the broken array multiplier; bits whose column
// i+ROW falls below VBL are removed.
module bam_pp_row #(
  parameter int DW  = 8,
  parameter int WW  = 8,
  parameter int VBL = 1,
  parameter int ROW = 0
) (
  input  logic [DW-1:0]    a,
  input  logic             b_bit,
  output logic [DW+WW-1:0] row
);
  localparam int PW = DW + WW;

  logic [DW-1:0] keep;

  for (genvar i = 0; i < DW; i++) begin : g_keep
    assign keep[i] = ((i + ROW) >= VBL) ? 1'b1 : 1'b0;
  end

  assign row = PW'(a & keep & {DW{b_bit}}) << ROW;
endmodule

// Broken array multiplier: unsigned A*B with the low VBL columns of the
// partial-product array dropped (VBL=0 gives the exact product).
module BAM_top #(
  parameter int DW  = 8,
  parameter int WW  = 8,
  parameter int VBL = 1
) (
  input  logic [DW-1:0]    A,
  input  logic [WW-1:0]    B,
  output logic [DW+WW-1:0] P
);
  localparam int PW = DW + WW;

  logic [WW-1:0][PW-1:0] rows;

  for (genvar j = 0; j < WW; j++) begin : g_row
    bam_pp_row #(.DW(DW), .WW(WW), .VBL(VBL), .ROW(j)) u_row (
      .a    (A),
      .b_bit(B[j]),
      .row  (rows[j])
    );
  end

  always_comb begin
    P = '0;
    for (int j = 0; j < WW; j++) P = P + rows[j];
  end
endmodule

module bam_rr_scheduler #(
  parameter int DW   = 8,
  parameter int WW   = 8,
  parameter int VBL  = 1,
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int CW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*WW-1:0]   req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DW+WW-1:0]     res_data,
  output logic [IDW-1:0]       res_id,
  output logic                 busy,
  output logic [CW-1:0]        op_count
);
  logic [NREQ-1:0][DW-1:0] a_lane;
  logic [NREQ-1:0][WW-1:0] b_lane;

  logic            s1_v;
  logic [DW-1:0]   s1_a;
  logic [WW-1:0]   s1_b;
  logic [IDW-1:0]  s1_id;
  logic [IDW-1:0]  rr_ptr;

  logic            s2_free, s1_adv, s1_free, accept;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_id;
  logic [DW+WW-1:0] prod;

  assign a_lane = req_a;
  assign b_lane = req_b;

  assign s2_free = !res_valid | res_ready;
  assign s1_adv  = s1_v & s2_free;
  assign s1_free = !s1_v | s1_adv;
  assign accept  = gnt_any & s1_free;
  assign busy    = s1_v | res_valid;

  // Winner is the valid requester at the smallest rotated distance from rr_ptr.
  always_comb begin
    int d, best;
    best    = NREQ;
    d       = 0;
    gnt_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(rr_ptr);
      if (d < 0) d = d + NREQ;
      if (req_valid[i] && d < best) begin
        best   = d;
        gnt_id = IDW'(i);
      end
    end
    gnt_any = (best < NREQ);
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_rdy
    assign req_ready[i] = rst_n & s1_free & gnt_any & (gnt_id == IDW'(i));
  end

  BAM_top #(.DW(DW), .WW(WW), .VBL(VBL)) u_bam (
    .A(s1_a),
    .B(s1_b),
    .P(prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      rr_ptr    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      op_count  <= '0;
    end else begin
      if (s1_adv) begin
        res_valid <= 1'b1;
        res_data  <= prod;
        res_id    <= s1_id;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end

      // A new accept may land in the same cycle S1 drains into S2.
      if (accept) begin
        s1_v   <= 1'b1;
        s1_a   <= a_lane[gnt_id];
        s1_b   <= b_lane[gnt_id];
        s1_id  <= gnt_id;
        rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      end else if (s1_adv) begin
        s1_v <= 1'b0;
      end

      if (res_valid && res_ready) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: doc/bam_rr_scheduler.md
Name: bam_rr_scheduler

Overview:
- Shares one BAM_top approximate multiplier instance among NREQ independent requesters.
- Round-robin arbitration selects one request per cycle. Operands are registered into an issue stage, multiplied combinationally by BAM_top, and captured in a result stage.
- Each result is tagged with the requester ID and has full valid/ready backpressure.
- Sits between PE-side operand producers and the accumulation logic.

Parameters:
- DW, 8, operand A width; passed to BAM_top.
- WW, 8, operand B width; passed to BAM_top.
- VBL, 1, vertical breaking level; passed to BAM_top (0 = exact product).
- NREQ, 4, number of requesters, 2..16.
- IDW, max(1, $clog2(NREQ)), requester ID width.
- CW, 16, width of the op counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, active-low.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*DW  packed A operands; requester i at [i*DW +: DW].
- req_b  in  NREQ*WW  packed B operands; requester i at [i*WW +: WW].
- res_valid  out  1  result valid.
- res_ready  in  1  consumer ready.
- res_data  out  DW+WW  BAM product.
- res_id  out  IDW  requester index of res_data.
- busy  out  1  high when any stage is occupied.
- op_count  out  CW  number of completed result handshakes; wraps.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-low (rst_n); all state updates on the rising edge of clk.
  - While rst_n is low: s1_v=0, s2_v=0, res_valid=0, res_data=0, res_id=0, rr_ptr=0, op_count=0, busy=0, req_ready=0.
  - Reset mid-operation discards in-flight ops with no output.
- Pipeline:
  - S1 register holds {a, b, id, s1_v}.
  - BAM_top(A=s1_a, B=s1_b) feeds S2 register {res_data, res_id, res_valid}.
- Advance rules:
  - s2_free = !res_valid | res_ready.
  - s1_adv = s1_v & s2_free moves S1 into S2.
  - s1_free = !s1_v | s1_adv.
  - If res_valid and !res_ready and !s1_adv, then res_valid stays 1.
- Arbitration:
  - Combinational round-robin over req_valid, starting at rr_ptr and wrapping NREQ-1 -> 0.
  - req_ready[g] = 1 only for the granted index g, and only when s1_free.
  - On handshake (req_valid[g] & req_ready[g]): S1 loads req_a/req_b slice g, id=g; rr_ptr <= (g+1) mod NREQ.
  - No handshake: rr_ptr unchanged.
- Handshake rules:
  - req_ready does not depend combinationally on res_ready except through s1_free.
  - Requesters must hold operands stable while valid is high and not accepted.
- Latency and throughput:
  - Accept at edge N -> res_valid=1 after edge N+1.
  - Throughput 1 op/cycle with res_ready held high.
- Full pipeline: with res_valid=1, s1_v=1 and res_ready=0, all req_ready=0.
- Simultaneous events: same-cycle S2 drain, S1->S2 move, and new accept are all permitted.
- Arithmetic:
  - Operands are unsigned; res_data equals the BAM_top output with no truncation.
  - With VBL=0, res_data = a*b exactly.
- Counters and status:
  - op_count increments on res_valid & res_ready and wraps 2^CW-1 -> 0.
  - busy = s1_v | res_valid.

Test Plan:
- Reset, then single op: NREQ=4, VBL=0; req 2 sends a=13, b=11 -> req_ready[2]=1 for one cycle; res_valid=1 two edges after reset release plus accept, with res_data=143, res_id=2; op_count=1.
- Round-robin fairness: all 4 req_valid held high, res_ready=1 -> accept order 0,1,2,3,0,1; one result per cycle after 2-cycle fill; 8 results in 9 cycles from first accept.
- Backpressure: stream 3 ops, res_ready=0 for 5 cycles -> first result held stable, s1 full, req_ready=0; release -> remaining results delivered in order, none lost or duplicated.
- Wrap and pointer hold: only req 3 valid -> grant 3, rr_ptr=0; then req 0 and 3 valid -> req 0 granted first; op_count preset near 0xFFFF via 65536 ops (or CW=4 build) wraps to 0.
- Reset mid-flight: assert rst_n=0 with both stages full -> next cycle res_valid=0, busy=0, op_count=0; no stale result emitted after release.
- Extremes, VBL=0: a=255, b=255 -> 65025; a=0, b=200 -> 0. With VBL=1, outputs match the BAM_top reference model bit-exactly.
